pc_branch_unit: RTL

- Sits directly downstream of the datapath ALU and consumes its 4-bit Status output {V,C,Z,N}.
- Holds the architectural NZCV flag register and the 64-bit program counter.
- Evaluates LEGv8 control-flow instructions: B, B.cond, CBZ, CBNZ and BR.
- Registers the next PC for the instruction-memory address path and reports whether the branch was taken.

---
 rtl/pc_branch_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pc_branch_unit.sv
// Program counter and NZCV flag register with LEGv8 control-flow evaluation
// (B, B.cond, CBZ, CBNZ, BR); next PC and branch-taken are registered.
module pc_branch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  status_in,
    input  logic        set_flags,
    input  logic        pc_en,
    input  logic [2:0]  branch_type,
    input  logic [3:0]  cond,
    input  logic [25:0] offset,
    input  logic [63:0] reg_target,
    output logic [63:0] pc_out,
    output logic [63:0] pc_plus4,
    output logic [3:0]  flags_out,
    output logic        taken
);

    localparam int unsigned PC_W    = 64;
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned IMM26_W = 26;
    localparam int unsigned IMM19_W = 19;

    typedef enum logic [2:0] {
        BT_NONE  = 3'b000,
        BT_B     = 3'b001,
        BT_BCOND = 3'b010,
        BT_CBZ   = 3'b011,
        BT_CBNZ  = 3'b100,
        BT_BR    = 3'b101
    } branch_type_e;

    // Status / flag bit positions in {V,C,Z,N} order
    localparam int unsigned FLAG_N = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

    logic [PC_W-1:0]   pc_q;
    logic [FLAG_W-1:0] flags_q;
    logic              taken_q;

    logic [PC_W-1:0]   off26;
    logic [PC_W-1:0]   off19;
    logic [PC_W-1:0]   seq_pc;
    logic [PC_W-1:0]   next_pc;
    logic              take;
    logic              cond_true;

    // Word-scaled, sign-extended branch displacements
    always_comb begin
        off26 = {{(PC_W - IMM26_W - 2){offset[IMM26_W-1]}}, offset, 2'b00};
        off19 = {{(PC_W - IMM19_W - 2){offset[IMM19_W-1]}}, offset[IMM19_W-1:0], 2'b00};
    end

    // Condition evaluation always uses the architectural (registered) flags
    always_comb begin
        logic fn, fz, fc, fv;
        fn = flags_q[FLAG_N];
        fz = flags_q[FLAG_Z];
        fc = flags_q[FLAG_C];
        fv = flags_q[FLAG_V];
        cond_true = 1'b0;
        case (cond)
            4'b0000: cond_true = fz;
            4'b0001: cond_true = ~fz;
            4'b0010: cond_true = fc;
            4'b0011: cond_true = ~fc;
            4'b0100: cond_true = fn;
            4'b0101: cond_true = ~fn;
            4'b0110: cond_true = fv;
            4'b0111: cond_true = ~fv;
            4'b1000: cond_true = fc & ~fz;
            4'b1001: cond_true = ~fc | fz;
            4'b1010: cond_true = (fn == fv);
            4'b1011: cond_true = (fn != fv);
            4'b1100: cond_true = ~fz & (fn == fv);
            4'b1101: cond_true = fz | (fn != fv);
            default: cond_true = 1'b1;
        endcase
    end

    // Branch decode; status_in is only looked at for CBZ/CBNZ so unknowns
    // on it cannot leak into the PC on other instruction types
    always_comb begin
        seq_pc  = pc_q + PC_W'(4);
        take    = 1'b0;
        next_pc = seq_pc;
        case (branch_type_e'(branch_type))
            BT_B: begin
                take    = 1'b1;
                next_pc = pc_q + off26;
            end
            BT_BCOND: begin
                take    = cond_true;
                next_pc = cond_true ? pc_q + off19 : seq_pc;
            end
            BT_CBZ: begin
                take    = (status_in[FLAG_Z] == 1'b1);
                next_pc = take ? pc_q + off19 : seq_pc;
            end
            BT_CBNZ: begin
                take    = (status_in[FLAG_Z] == 1'b0);
                next_pc = take ? pc_q + off19 : seq_pc;
            end
            BT_BR: begin
                take    = 1'b1;
                next_pc = reg_target;
            end
            default: begin
                take    = 1'b0;
                next_pc = seq_pc;
            end
        endcase
    end

    // Architectural state; reset dominates, pc_en gates every update
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            flags_q <= '0;
            taken_q <= 1'b0;
        end else if (pc_en) begin
            pc_q    <= next_pc;
            taken_q <= take;
            if (set_flags) begin
                flags_q <= status_in;
            end
        end
    end

    assign pc_out    = pc_q;
    assign pc_plus4  = seq_pc;
    assign flags_out = flags_q;
    assign taken     = taken_q;

endmodule
